// File: rtl/mem_ctrl_pkg.sv
// Shared encodings and lane helpers for the MEM-stage data-memory controller.
package mem_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            SZ_B:    be = 4'b0001 << a;
            SZ_H:    be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_gen(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] w;
        case (size)
            SZ_B:    w = {4{wd[7:0]}};
            SZ_H:    w = {2{wd[15:0]}};
            default: w = wd;
        endcase
        return w;
    endfunction

    // Size code 3 is a word access, so it shares the word alignment rule.
    function automatic logic addr_misaligned(input logic [1:0] size, input logic [1:0] a);
        logic mis;
        case (size)
            SZ_B:    mis = 1'b0;
            SZ_H:    mis = a[0];
            default: mis = (a != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Word-wide data-memory req/ack bus between the MEM-stage controller and the memory.
interface mem_access_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        be;
    logic              ack;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access_ctrl_load_align.sv
// Combinational load lane extraction with sign/zero extension (little-endian).
import mem_ctrl_pkg::*;

module load_align (
    input  logic [31:0] rdata,
    input  logic [1:0]  a,
    input  logic [1:0]  size,
    input  logic        uns,
    output logic [31:0] data
);
    logic [31:0]       shifted;
    logic signed [7:0]  lane_b;
    logic signed [15:0] lane_h;

    always_comb begin
        shifted = rdata >> {a, 3'b000};
        lane_b  = shifted[7:0];
        lane_h  = shifted[15:0];
        case (size)
            SZ_B:    data = uns ? {24'd0, lane_b} : 32'(lane_b);
            SZ_H:    data = uns ? {16'd0, lane_h} : 32'(lane_h);
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory initiator: IDLE -> REQ -> RESP, byte lanes, load extension, stall.
// Optional REQ timeout abort is enabled by defining MEM_TIMEOUT_EN.
import mem_ctrl_pkg::*;

module mem_access_ctrl #(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic        ex_mem_to_reg,
    input  logic [1:0]  ex_size,
    input  logic        ex_unsigned,
    input  logic [31:0] ex_alu_res,
    input  logic [31:0] ex_write_data,
    output logic        stall,
    output logic        out_valid,
    output logic [31:0] out_data,
    output logic        misaligned,
    output logic        err,
    mem_access_ctrl_if.master dm
);
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    logic [1:0]  state;
    logic        m2r_q;
    logic        uns_q;
    logic [1:0]  size_q;
    logic [1:0]  a_q;
    logic [31:0] alu_q;
    logic [31:0] load_val;
    logic [1:0]  ex_a;
    logic        ex_is_mem;
    logic        ex_mis;

    assign ex_a      = ex_alu_res[1:0];
    assign ex_is_mem = ex_mem_read | ex_mem_write;
    assign ex_mis    = addr_misaligned(ex_size, ex_a);
    assign stall     = (state != ST_IDLE);

    // Fed straight from the bus so the ack cycle can register the final write-back value.
    load_align u_load_align (
        .rdata (dm.rdata),
        .a     (a_q),
        .size  (size_q),
        .uns   (uns_q),
        .data  (load_val)
    );

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [CNT_W-1:0] req_cnt;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            out_valid  <= 1'b0;
            out_data   <= '0;
            misaligned <= 1'b0;
            dm.req     <= 1'b0;
            dm.we      <= 1'b0;
            dm.addr    <= '0;
            dm.wdata   <= '0;
            dm.be      <= '0;
            m2r_q      <= 1'b0;
            uns_q      <= 1'b0;
            size_q     <= SZ_W;
            a_q        <= 2'b00;
            alu_q      <= '0;
`ifdef MEM_TIMEOUT_EN
            err        <= 1'b0;
            req_cnt    <= '0;
`endif
        end else begin
            out_valid  <= 1'b0;
            misaligned <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            err        <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (ex_valid) begin
                        if (!ex_is_mem) begin
                            out_valid <= 1'b1;
                            out_data  <= ex_alu_res;
                        end else if (ex_mis) begin
                            out_valid  <= 1'b1;
                            misaligned <= 1'b1;
                            out_data   <= '0;
                        end else begin
                            state    <= ST_REQ;
                            dm.req   <= 1'b1;
                            dm.we    <= ex_mem_write;
                            dm.addr  <= ex_alu_res[ADDR_W+1:2];
                            dm.wdata <= wdata_gen(ex_size, ex_write_data);
                            dm.be    <= be_gen(ex_size, ex_a);
                            m2r_q    <= ex_mem_to_reg;
                            uns_q    <= ex_unsigned;
                            size_q   <= ex_size;
                            a_q      <= ex_a;
                            alu_q    <= ex_alu_res;
`ifdef MEM_TIMEOUT_EN
                            req_cnt  <= '0;
`endif
                        end
                    end
                end
                ST_REQ: begin
                    // Ack is checked first so an ack in the last allowed cycle beats the timeout.
                    if (dm.ack) begin
                        dm.req    <= 1'b0;
                        state     <= ST_RESP;
                        out_valid <= 1'b1;
                        out_data  <= m2r_q ? load_val : alu_q;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (req_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        dm.req    <= 1'b0;
                        state     <= ST_IDLE;
                        out_valid <= 1'b1;
                        err       <= 1'b1;
                        out_data  <= '0;
                    end else begin
                        req_cnt <= req_cnt + 1'b1;
                    end
`endif
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a byte-lane reference model.
module tb_mem_access_ctrl;
    localparam int ADDR_W = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_unsigned;
    logic [1:0]  ex_size;
    logic [31:0] ex_alu_res, ex_write_data;
    logic        stall, out_valid, misaligned, err;
    logic [31:0] out_data;

    int n_total = 0;
    int n_bad   = 0;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W)) dm ();

    mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(8)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_mem_read   (ex_mem_read),
        .ex_mem_write  (ex_mem_write),
        .ex_mem_to_reg (ex_mem_to_reg),
        .ex_size       (ex_size),
        .ex_unsigned   (ex_unsigned),
        .ex_alu_res    (ex_alu_res),
        .ex_write_data (ex_write_data),
        .stall         (stall),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .misaligned    (misaligned),
        .err           (err),
        .dm            (dm.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_ex();
        ex_mem_read   = 1'($urandom);
        ex_mem_write  = 1'($urandom);
        ex_mem_to_reg = 1'($urandom);
        ex_size       = 2'($urandom);
        ex_unsigned   = 1'($urandom);
        ex_alu_res    = $urandom;
        ex_write_data = $urandom;
    endtask

    // Expected results are derived from byte counts and byte offsets, not from the RTL encodings.
    task automatic run_op(input logic rd, input logic wr, input logic m2r, input logic [1:0] sz,
                          input logic uns, input logic [31:0] alu, input logic [31:0] wd,
                          input int lat, input logic [31:0] rdata);
        int          nbytes, stall_cnt;
        logic        is_mem, mis;
        logic [3:0]  e_be;
        logic [31:0] e_wd, e_load, v, e_out;

        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        is_mem = rd | wr;
        mis    = is_mem && ((alu % 32'(nbytes)) != 0);
        e_be   = (nbytes == 4) ? 4'hF : 4'(((nbytes == 1) ? 1 : 3) << alu[1:0]);
        e_wd   = (nbytes == 1) ? wd[7:0] * 32'h0101_0101 :
                 (nbytes == 2) ? wd[15:0] * 32'h0001_0001 : wd;
        v      = rdata >> (8 * alu[1:0]);
        if (nbytes == 1) begin
            e_load = v & 32'hFF;
            if (!uns && e_load >= 32'd128) e_load = e_load - 32'd256;
        end else if (nbytes == 2) begin
            e_load = v & 32'hFFFF;
            if (!uns && e_load >= 32'd32768) e_load = e_load - 32'd65536;
        end else begin
            e_load = rdata;
        end
        e_out = !is_mem ? alu : mis ? 32'd0 : (m2r ? e_load : alu);

        ex_valid = 1'b1; ex_mem_read = rd; ex_mem_write = wr; ex_mem_to_reg = m2r;
        ex_size = sz; ex_unsigned = uns; ex_alu_res = alu; ex_write_data = wd;
        dm.ack = 1'($urandom); dm.rdata = $urandom;
        step();
        scramble_ex();
        dm.ack = 1'b0;

        if (!is_mem || mis) begin
            ex_valid = 1'b0;
            chk("imm_valid", 32'(out_valid), 32'd1);
            chk("imm_data", out_data, e_out);
            chk("imm_misaligned", 32'(misaligned), 32'(mis));
            chk("imm_stall", 32'(stall), 32'd0);
            chk("imm_no_req", 32'(dm.req), 32'd0);
            step();
            chk("imm_pulse_end", 32'({out_valid, misaligned}), 32'd0);
        end else begin
            ex_valid  = 1'($urandom);
            stall_cnt = 0;
            chk("req_up", 32'(dm.req), 32'd1);
            chk("req_we", 32'(dm.we), 32'(wr));
            chk("req_addr", 32'(dm.addr), 32'(alu[ADDR_W+1:2]));
            chk("req_be", 32'(dm.be), 32'(e_be));
            if (wr) chk("req_wdata", dm.wdata, e_wd);
            chk("req_no_valid", 32'(out_valid), 32'd0);
            if (stall) stall_cnt++;
            for (int i = 0; i < lat; i++) begin
                dm.ack = 1'b0;
                step();
                chk("req_hold", 32'({dm.req, out_valid}), 32'b10);
                if (stall) stall_cnt++;
            end
            dm.ack = 1'b1; dm.rdata = rdata;
            step();
            dm.ack = 1'($urandom); dm.rdata = $urandom;
            chk("resp_valid", 32'(out_valid), 32'd1);
            chk("resp_data", out_data, e_out);
            chk("resp_req_low", 32'(dm.req), 32'd0);
            chk("resp_err", 32'(err), 32'd0);
            if (stall) stall_cnt++;
            step();
            ex_valid = 1'b0; dm.ack = 1'b0;
            chk("stall_cycles", 32'(stall_cnt), 32'(lat + 2));
            chk("done_idle", 32'({stall, out_valid}), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; ex_valid = 1'b0; dm.ack = 1'b0; dm.rdata = '0;
        scramble_ex();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({stall, out_valid, misaligned, err, dm.req, dm.we}), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_addr", 32'(dm.addr), 32'd0);
        chk("rst_wdata", dm.wdata, 32'd0);
        chk("rst_be", 32'(dm.be), 32'd0);
        rst_n = 1'b1;
        step();

        run_op(1, 0, 1, 2'd2, 0, 32'h10, 32'h0, 2, 32'hDEAD_BEEF);      // lw, ack on third REQ cycle
        run_op(1, 0, 1, 2'd0, 0, 32'h13, 32'h0, 0, 32'h80FF_0102);      // lb zero-wait
        run_op(1, 0, 1, 2'd0, 1, 32'h13, 32'h0, 0, 32'h80FF_0102);      // lbu
        run_op(0, 1, 0, 2'd1, 0, 32'h06, 32'h1234_ABCD, 1, 32'h0);      // sh
        run_op(1, 0, 1, 2'd2, 0, 32'h02, 32'h0, 0, 32'h0);              // misaligned lw
        run_op(1, 0, 1, 2'd1, 0, 32'h0B, 32'h0, 0, 32'h0);              // misaligned lh
        run_op(0, 0, 0, 2'd2, 0, 32'hCAFE_F00D, 32'h0, 0, 32'h0);       // no memory access
        run_op(1, 1, 0, 2'd0, 0, 32'h3FD, 32'h55, 0, 32'h0);            // write wins
        run_op(1, 0, 1, 2'd1, 0, 32'h22, 32'h0, 3, 32'h8001_7FFE);      // lh upper half, negative
        run_op(1, 0, 1, 2'd3, 0, 32'h44, 32'h0, 0, 32'h1357_9BDF);      // size 3 behaves as word

        // Reset while a request is outstanding must drop it at once and lose the op.
        ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_mem_to_reg = 1'b1;
        ex_size = 2'd2; ex_unsigned = 1'b0; ex_alu_res = 32'h20; dm.ack = 1'b0;
        step();
        ex_valid = 1'b0;
        chk("rst_mid_req_up", 32'(dm.req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_req_drop", 32'({dm.req, stall, out_valid}), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("rst_mid_no_valid", 32'({out_valid, stall}), 32'd0);
        run_op(1, 0, 1, 2'd2, 0, 32'h24, 32'h0, 1, 32'h0BAD_F00D);

`ifdef MEM_TIMEOUT_EN
        begin
            int req_cycles;
            ex_valid = 1'b1; ex_mem_read = 1'b1; ex_mem_write = 1'b0; ex_mem_to_reg = 1'b1;
            ex_size = 2'd2; ex_alu_res = 32'h40; dm.ack = 1'b0;
            step();
            ex_valid = 1'b0;
            req_cycles = 0;
            while (dm.req && req_cycles < 20) begin
                req_cycles++;
                step();
            end
            chk("to_req_cycles", 32'(req_cycles), 32'd8);
            chk("to_err", 32'({err, out_valid, stall}), 32'b110);
            chk("to_data", out_data, 32'd0);
            step();
            chk("to_err_pulse", 32'({err, out_valid}), 32'd0);
        end
`endif

        for (int n = 0; n < 200; n++) begin
            logic        rd, wr;
            logic [1:0]  sz;
            logic [31:0] alu;
            rd  = 1'($urandom);
            wr  = 1'($urandom);
            sz  = 2'($urandom);
            alu = $urandom;
            if ($urandom_range(3) != 0)
                alu = alu & ~((sz == 2'd0) ? 32'd0 : (sz == 2'd1) ? 32'd1 : 32'd3);
            run_op(rd, wr, 1'($urandom), sz, 1'($urandom), alu, $urandom,
                   int'($urandom_range(5)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
